// File: rtl/out_scan_if.sv
// Bus between the processor-side write port, the display-side scan outputs
// and the scan controller.
// Handshake: none; every signal is sampled on the rising clock edge,
// writes are fire-and-forget and scan_start is a 1-cycle strobe.
interface out_scan_if #(
   parameter int DATA_W = 16
);
   logic              wr_en1;
   logic              wr_en2;
   logic [2:0]        wr_sel;
   logic [DATA_W-1:0] wr_val1;
   logic [DATA_W-1:0] wr_val2;
   logic              clear;
   logic              hold;
   logic [2:0]        scan_sel;
   logic [DATA_W-1:0] scan_val1;
   logic [DATA_W-1:0] scan_val2;
   logic              scan_show1;
   logic              scan_show2;
   logic              scan_start;
   logic              dbg_state;

   modport master (
      output wr_en1, wr_en2, wr_sel, wr_val1, wr_val2, clear, hold,
      input  scan_sel, scan_val1, scan_val2, scan_show1, scan_show2, scan_start,
      input  dbg_state
   );

   modport slave (
      input  wr_en1, wr_en2, wr_sel, wr_val1, wr_val2, clear, hold,
      output scan_sel, scan_val1, scan_val2, scan_show1, scan_show2, scan_start,
      output dbg_state
   );
endinterface

// File: rtl/out_scan_ctrl.sv
// 8-slot output table with a registered display scan: one slot is presented
// for DWELL cycles, with same-cycle writes forwarded to the displayed slot.
module out_scan_ctrl #(
   parameter int DATA_W     = 16,
   parameter int DWELL      = 16,
   parameter bit SKIP_EMPTY = 1'b0
) (
   input logic        clock,
   input logic        reset,
   out_scan_if.slave  bus
);
   localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 2);

   typedef enum logic {S_LOAD = 1'b0, S_DWELL = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [2:0]        sel, sel_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              start_nxt;

   logic [DATA_W-1:0] tbl_val1 [8];
   logic [DATA_W-1:0] tbl_val2 [8];
   logic [7:0]        tbl_show1;
   logic [7:0]        tbl_show2;

   logic [2:0]        disp_sel;
   logic              hit;
   logic [DATA_W-1:0] fwd_val1, fwd_val2;
   logic              fwd_show1, fwd_show2;
   logic [7:0]        occ;
   logic [2:0]        next_slot;
   logic [2:0]        idx;
   logic              found;

   // Later assignment wins, so a write overrides a same-cycle clear for its field.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            tbl_val1[i] <= '0;
            tbl_val2[i] <= '0;
         end
         tbl_show1 <= '0;
         tbl_show2 <= '0;
      end else begin
         if (bus.clear) begin
            tbl_show1 <= '0;
            tbl_show2 <= '0;
         end
         if (bus.wr_en1) begin
            tbl_val1[bus.wr_sel]  <= bus.wr_val1;
            tbl_show1[bus.wr_sel] <= 1'b1;
         end
         if (bus.wr_en2) begin
            tbl_val2[bus.wr_sel]  <= bus.wr_val2;
            tbl_show2[bus.wr_sel] <= 1'b1;
         end
      end
   end

   // The slot the outputs will show after this edge, and its post-write contents.
   always_comb begin
      disp_sel  = (state == S_LOAD && !bus.hold) ? sel : bus.scan_sel;
      hit       = (bus.wr_sel == disp_sel);
      fwd_val1  = (bus.wr_en1 && hit) ? bus.wr_val1 : tbl_val1[disp_sel];
      fwd_val2  = (bus.wr_en2 && hit) ? bus.wr_val2 : tbl_val2[disp_sel];
      fwd_show1 = (bus.wr_en1 && hit) || (!bus.clear && tbl_show1[disp_sel]);
      fwd_show2 = (bus.wr_en2 && hit) || (!bus.clear && tbl_show2[disp_sel]);
   end

   // Circular search starting after sel; sel itself is the last candidate.
   always_comb begin
      occ       = tbl_show1 | tbl_show2;
      next_slot = sel + 3'd1;
      idx       = '0;
      found     = 1'b0;
      if (SKIP_EMPTY) begin
         for (int i = 1; i <= 8; i++) begin
            idx = sel + 3'(i);
            if (!found && occ[idx]) begin
               next_slot = idx;
               found     = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_LOAD;
         sel   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      cnt_nxt   = cnt;
      start_nxt = 1'b0;
      if (!bus.hold) begin
         case (state)
            S_LOAD: begin
               start_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_DWELL;
            end
            S_DWELL: begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  sel_nxt   = next_slot;
                  state_nxt = S_LOAD;
               end
            end
            default: state_nxt = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.scan_sel   <= '0;
         bus.scan_val1  <= '0;
         bus.scan_val2  <= '0;
         bus.scan_show1 <= 1'b0;
         bus.scan_show2 <= 1'b0;
         bus.scan_start <= 1'b0;
      end else begin
         bus.scan_sel   <= disp_sel;
         bus.scan_val1  <= fwd_val1;
         bus.scan_val2  <= fwd_val2;
         bus.scan_show1 <= fwd_show1;
         bus.scan_show2 <= fwd_show2;
         bus.scan_start <= start_nxt;
      end
   end

   assign bus.dbg_state = (state == S_DWELL);
endmodule

// File: tb/tb_out_scan_ctrl.sv
// Directed bench: u0 sequential scan (DWELL=16), u1 skip-empty scan (DWELL=4).
module tb_out_scan_ctrl;
   logic clock;
   logic reset;
   int   cyc;
   int   vectors;
   int   miscompares;
   int   starts;
   int   moved;

   out_scan_if #(.DATA_W(16)) if0 ();
   out_scan_if #(.DATA_W(16)) if1 ();

   out_scan_ctrl #(.DATA_W(16), .DWELL(16), .SKIP_EMPTY(1'b0)) u0 (
      .clock(clock), .reset(reset), .bus(if0)
   );
   out_scan_ctrl #(.DATA_W(16), .DWELL(4), .SKIP_EMPTY(1'b1)) u1 (
      .clock(clock), .reset(reset), .bus(if1)
   );

   // clock/reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; starts = 0; moved = 0;
      reset = 1'b1;
      if0.wr_en1 = 0; if0.wr_en2 = 0; if0.wr_sel = 0; if0.wr_val1 = 0; if0.wr_val2 = 0;
      if0.clear = 0; if0.hold = 0;
      if1.wr_en1 = 0; if1.wr_en2 = 0; if1.wr_sel = 0; if1.wr_val1 = 0; if1.wr_val2 = 0;
      if1.clear = 0; if1.hold = 0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_sel", 32'(if0.scan_sel), 0);
      check("rst_start", 32'(if0.scan_start), 0);
      check("rst_val1", 32'(if0.scan_val1), 0);
      check("rst_show", 32'({if0.scan_show1, if0.scan_show2}), 0);
      check("rst_state", 32'(if0.dbg_state), 0);
      reset = 1'b0;
      cyc = 0;

      // sequential scan, DWELL=16
      step_to(1);
      check("c1_start", 32'(if0.scan_start), 1);
      check("c1_sel", 32'(if0.scan_sel), 0);
      step_to(2);
      check("c2_start", 32'(if0.scan_start), 0);
      step_to(16);
      check("c16_sel", 32'(if0.scan_sel), 0);
      check("c16_start", 32'(if0.scan_start), 0);
      step_to(17);
      check("c17_start", 32'(if0.scan_start), 1);
      check("c17_sel", 32'(if0.scan_sel), 1);
      if0.wr_en1 = 1; if0.wr_sel = 3'd5; if0.wr_val1 = 16'h0007;
      step();
      if0.wr_en1 = 0;
      step_to(33);
      check("c33_sel", 32'(if0.scan_sel), 2);
      check("c33_start", 32'(if0.scan_start), 1);
      check("c33_show1", 32'(if0.scan_show1), 0);

      // forward a write into the displayed slot
      step_to(40);
      if0.wr_en2 = 1; if0.wr_sel = 3'd2; if0.wr_val2 = 16'hBEEF;
      step();
      if0.wr_en2 = 0;
      check("fwd_val2", 32'(if0.scan_val2), 32'hBEEF);
      check("fwd_show2", 32'(if0.scan_show2), 1);
      check("fwd_start", 32'(if0.scan_start), 0);
      check("fwd_sel", 32'(if0.scan_sel), 2);
      step_to(48);
      check("c48_start", 32'(if0.scan_start), 0);
      step_to(49);
      check("c49_start", 32'(if0.scan_start), 1);
      check("c49_sel", 32'(if0.scan_sel), 3);

      step_to(81);
      check("s5_sel", 32'(if0.scan_sel), 5);
      check("s5_val1", 32'(if0.scan_val1), 32'h0007);
      check("s5_show1", 32'(if0.scan_show1), 1);
      check("s5_show2", 32'(if0.scan_show2), 0);

      // hold 40 cycles mid-dwell
      step_to(86);
      if0.hold = 1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (if0.scan_start) starts++;
         if (if0.scan_sel != 3'd5) moved++;
      end
      if0.hold = 0;
      check("hold_starts", 32'(starts), 0);
      check("hold_moved", 32'(moved), 0);
      step_to(136);
      check("c136_sel", 32'(if0.scan_sel), 5);
      check("c136_start", 32'(if0.scan_start), 0);
      step_to(137);
      check("c137_sel", 32'(if0.scan_sel), 6);
      check("c137_start", 32'(if0.scan_start), 1);

      // clear racing a write to slot 3
      if0.wr_en1 = 1; if0.wr_sel = 3'd1; if0.wr_val1 = 16'h1111;
      step();
      if0.wr_sel = 3'd3; if0.wr_val1 = 16'h3333;
      step();
      if0.clear = 1; if0.wr_val1 = 16'h3334;
      step();
      if0.clear = 0; if0.wr_en1 = 0;
      step_to(185);
      check("s1_sel", 32'(if0.scan_sel), 1);
      check("s1_val1", 32'(if0.scan_val1), 32'h1111);
      check("s1_show1", 32'(if0.scan_show1), 0);
      step_to(201);
      check("s2_val2", 32'(if0.scan_val2), 32'hBEEF);
      check("s2_show2", 32'(if0.scan_show2), 0);
      step_to(217);
      check("s3_sel", 32'(if0.scan_sel), 3);
      check("s3_val1", 32'(if0.scan_val1), 32'h3334);
      check("s3_show1", 32'(if0.scan_show1), 1);

      // asynchronous reset mid-slot
      step_to(222);
      reset = 1'b1;
      #1;
      check("arst_sel", 32'(if0.scan_sel), 0);
      check("arst_val1", 32'(if0.scan_val1), 0);
      check("arst_show1", 32'(if0.scan_show1), 0);
      check("arst_state", 32'(if0.dbg_state), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      cyc = 0;

      // skip-empty scan, DWELL=4
      step_to(1);
      check("k1_sel", 32'(if1.scan_sel), 0);
      check("k1_start", 32'(if1.scan_start), 1);
      if1.wr_en1 = 1; if1.wr_sel = 3'd2; if1.wr_val1 = 16'h00A2;
      step();
      if1.wr_en1 = 0; if1.wr_en2 = 1; if1.wr_sel = 3'd6; if1.wr_val2 = 16'h00B6;
      step();
      if1.wr_en2 = 0;
      step_to(5);
      check("k5_sel", 32'(if1.scan_sel), 2);
      check("k5_val1", 32'(if1.scan_val1), 32'h00A2);
      check("k5_show1", 32'(if1.scan_show1), 1);
      step_to(9);
      check("k9_sel", 32'(if1.scan_sel), 6);
      check("k9_val2", 32'(if1.scan_val2), 32'h00B6);
      check("k9_show2", 32'(if1.scan_show2), 1);
      check("k9_show1", 32'(if1.scan_show1), 0);
      step_to(13);
      check("k13_sel", 32'(if1.scan_sel), 2);
      if1.clear = 1;
      step();
      if1.clear = 0;
      check("k14_show1", 32'(if1.scan_show1), 0);
      step_to(17);
      check("k17_sel", 32'(if1.scan_sel), 3);
      step_to(21);
      check("k21_sel", 32'(if1.scan_sel), 4);
      step_to(22);
      reset = 1'b1;
      #1;
      check("k_arst_sel", 32'(if1.scan_sel), 0);
      check("k_arst_start", 32'(if1.scan_start), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
